// File: rtl/serial_rx_deframer_pkg.sv
// Shared definitions for the serial receive deframer: FSM state encoding and line levels.
package serial_rx_deframer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/serial_rx_deframer_bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to RESET_VAL.
module bit_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx_deframer.sv
// Oversampling serial frame receiver: start-bit qualification, LSB-first assembly, stop-bit check.
// Build option SERIAL_RX_SYNC_EN inserts a 2-flop synchronizer on rx_in (+2 cycles latency).
module serial_rx_deframer
  import serial_rx_deframer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] out_byte,
  output logic                  out_valid,
  output logic                  frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic                  s;
  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] sh;

`ifdef SERIAL_RX_SYNC_EN
  bit_sync #(
    .RESET_VAL(LINE_IDLE)
  ) u_sync (
    .clk (clk),
    .arst(arst),
    .d   (rx_in),
    .q   (s)
  );
`else
  assign s = rx_in;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (s == START_BIT) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Mid-bit recheck rejects glitches shorter than half a bit.
          if (cnt == CNT_HALF) begin
            if (s == START_BIT) begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            sh  <= {s, sh[DATA_WIDTH-1:1]};
            cnt <= '0;
            if (idx == IDX_LAST) state <= STOP;
            else                 idx   <= idx + IDX_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (s == LINE_IDLE) begin
              out_byte  <= sh;
              out_valid <= 1'b1;
              state     <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          // A held-low (break) line must return high before a new start is accepted.
          if (s == LINE_IDLE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_rx_deframer.md
# serial_rx_deframer

- Upstream stage of the parity decoder in the receive path.
- Oversamples the asynchronous serial line `rx_in` and detects start bits.
- Assembles `DATA_WIDTH`-bit words, LSB first, and checks the stop bit.
- Presents each completed word on `out_byte` with a one-cycle `out_valid` strobe. The word includes the parity bit, and the parity decoder consumes it unchanged.

## Interface
- `DATA_WIDTH`, default 8: bits per frame between start and stop bit, parity bit included.
- `CLKS_PER_BIT`, default 16: `clk` cycles per serial bit. Must be even and ≥ 4.
- `clk` input, 1 bit: clock, rising edge.
- `arst` input, 1 bit: reset, asynchronous, active-high.
- `rx_in` input, 1 bit: serial line. Idle high, start bit 0, stop bit 1.
- `out_byte` output, `DATA_WIDTH` bits: last correctly framed word. Holds until the next good frame.
- `out_valid` output, 1 bit: one-cycle strobe, asserted when `out_byte` updates.
- `frame_err` output, 1 bit: one-cycle strobe when the stop bit samples 0.

## Operation
- Internal sample `s` is `rx_in`, or its synchronized copy (see Configuration).
- Counter `cnt`: width $clog2(CLKS_PER_BIT). Bit index `idx`: width $clog2(DATA_WIDTH). Shift register `sh`: `DATA_WIDTH` bits.
- State machine, states IDLE, START, DATA, STOP, WAIT_IDLE:
  - IDLE: if `s`=0, go to START with `cnt`=0. Otherwise stay in IDLE.
  - START: `cnt`++ each cycle. At `cnt`=CLKS_PER_BIT/2−1, sample `s`:
    - `s`=0: go to DATA with `cnt`=0, `idx`=0.
    - `s`=1: false start, go to IDLE.
  - DATA: `cnt`++ each cycle. At `cnt`=CLKS_PER_BIT−1:
    - `sh` <= {`s`, `sh`[DATA_WIDTH-1:1]}, `cnt`=0.
    - If `idx`=DATA_WIDTH−1, go to STOP. Otherwise `idx`++.
  - STOP: at `cnt`=CLKS_PER_BIT−1, sample `s`:
    - `s`=1: `out_byte` <= `sh`, `out_valid` <= 1, go to IDLE.
    - `s`=0: `frame_err` <= 1, `out_byte` unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `s`=1, then go to IDLE. This prevents a break condition from re-triggering as a start bit.
- `out_valid` and `frame_err` are registered. Each is high for exactly one cycle and they are never high together.
- No parity evaluation in this block. Parity checking belongs to the downstream decoder.

## Timing
- Reset values:
  - State IDLE.
  - `cnt`, `idx`, `sh` = 0.
  - `out_byte` = 0, `out_valid` = 0, `frame_err` = 0.
  - Synchronizer flops = 1.
- `arst` mid-frame aborts immediately. No strobe is produced. The first falling edge after release starts a new frame.
- Let E0 be the edge on which IDLE sees `s`=0 (N = CLKS_PER_BIT, W = DATA_WIDTH):
  - Start-bit check at E0+N/2.
  - Data bit k sampled at E0+N/2+(k+1)·N.
  - Stop bit sampled at E0+N/2+(W+1)·N.
  - `out_valid`/`frame_err` high in the following cycle only.
- Back-to-back frames: the next start bit may begin immediately after the stop bit. IDLE is reached about N/2 cycles before the stop bit ends, so there is no dead time.
- A low glitch shorter than N/2 cycles produces no output.
- `rx_in` is asynchronous to `clk`.

## Configuration
- Macro: `SERIAL_RX_SYNC_EN`.
- Defined: `rx_in` passes through a 2-flop synchronizer, both flops reset to 1, and `s` is its output. All event times above shift by +2 cycles.
- Undefined: `s` = `rx_in` directly. Use only when the line is already synchronous to `clk`.

## Structure
- Shared package holds:
  - State encoding constants IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4 (3 bits).
  - Line levels LINE_IDLE=1, START_BIT=0.
- One sub-module, `bit_sync`: a 2-flop synchronizer with parameterized reset value. It is instantiated only under `SERIAL_RX_SYNC_EN`.

## Test plan
All scenarios use N=16, W=8, macro defined.
- Good frame: send 0xA7 (start 0, bits 1,1,1,0,0,1,0,1, stop 1). Required: `out_byte`=0xA7, `out_valid` high for 1 cycle at E0+N/2+9N+1 after sync delay, `frame_err`=0.
- Framing error: send 0x3C with stop bit 0, line held low 3N cycles, then high. Required: `frame_err` pulses once, no `out_valid`, `out_byte` keeps its previous value, no new frame starts until the line is high.
- False start: drive `rx_in` low for 5 cycles, then high. Required: no strobe, state returns to IDLE.
- Back-to-back: 0x55 immediately followed by 0xFE. Required: two `out_valid` pulses exactly 10·N cycles apart, values 0x55 then 0xFE.
- Reset mid-frame: assert `arst` during data bit 4 of 0x81, release, then send 0x12. Required: outputs 0 during reset, no strobe for 0x81, `out_byte`=0x12 with one `out_valid`.
- Macro off: repeat the good-frame test. Required: `out_valid` arrives 2 cycles earlier than with the macro defined.
